// File: rtl/ifu_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package ifu_prefetch_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {BOOT, RUN} pf_state_e;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/ifu_fifo.sv
// Synchronous instruction buffer; flush empties it in one cycle.
module ifu_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;

  assign do_push = push & (count != FULL);
  assign do_pop  = pop & (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: credit-limited issue, in-order response buffering,
// redirect flush with discard of in-flight responses.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic [INST_W-1:0] inst_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CREDITS = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  pf_state_e         state, state_n;
  logic [ADDR_W-1:0] fetch_addr, out_pc;
  logic [AW:0]       outstanding, discard, count;
  logic [AW+1:0]     inflight;
  logic [INST_W-1:0] head;
  logic              gnt_fire, rsp_ok, rsp_drop, push, pop;

  // Credits use registered occupancy only; a pop this cycle frees a slot next cycle.
  assign inflight = {1'b0, outstanding} + {1'b0, count};

  always_comb begin
    state_n   = state;
    mem_req_o = 1'b0;
    case (state)
      BOOT: state_n = RUN;
      RUN:  mem_req_o = ~flush_i & (inflight < {1'b0, CREDITS});
    endcase
  end

  // Responses with nothing outstanding are protocol errors and are ignored.
  assign gnt_fire = mem_req_o & mem_gnt_i;
  assign rsp_ok   = mem_rvalid_i & (outstanding != '0);
  assign rsp_drop = rsp_ok & (discard != '0);
  assign push     = rsp_ok & ~rsp_drop & ~flush_i;
  assign pop      = inst_valid_o & inst_ready_i & ~flush_i;

  assign mem_addr_o   = fetch_addr;
  assign inst_valid_o = (count != '0);
  assign inst_pc_o    = out_pc;
  assign inst_o       = inst_valid_o ? head : NOP_INST;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      fetch_addr  <= RESET_PC;
      out_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state <= state_n;
      case ({gnt_fire, rsp_ok})
        2'b10:   outstanding <= outstanding + ONE;
        2'b01:   outstanding <= outstanding - ONE;
        default: ;
      endcase
      if (flush_i) begin
        // Every response still owed after this cycle belongs to the old stream.
        fetch_addr <= word_align(flush_pc_i);
        out_pc     <= word_align(flush_pc_i);
        discard    <= rsp_ok ? outstanding - ONE : outstanding;
      end else begin
        if (gnt_fire) fetch_addr <= fetch_addr + 32'd4;
        if (pop)      out_pc     <= out_pc + 32'd4;
        if (rsp_drop) discard    <= discard - ONE;
      end
    end
  end

  ifu_fifo #(.WIDTH(INST_W), .DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (mem_rdata_i),
    .pop   (pop),
    .flush (flush_i),
    .count (count),
    .head  (head)
  );

  a_rvalid_owed: assert property (@(posedge clk) disable iff (!rst)
    mem_rvalid_i |-> (outstanding != '0));
endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench: reset, streaming, backpressure, grant stall and redirect flushes.
module tb_ifu_prefetch;
  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_pc_o;
  logic [31:0] inst_o;

  int checks = 0;
  int failures = 0;
  int gnt_cnt = 0;
  int pop_cnt = 0;
  logic        hold = 1'b0;
  logic        sb_en = 1'b0;
  logic [31:0] exp_pc = '0;
  logic [31:0] q[$];

  ifu_prefetch dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_pc_o(inst_pc_o), .inst_o(inst_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: scoreboard pops, record grants, then the memory returns one response per cycle.
  task automatic cyc();
    #1;
    if (sb_en && inst_valid_o && inst_ready_i && !flush_i) begin
      check("sb_pc", inst_pc_o, exp_pc);
      check("sb_inst", inst_o, exp_pc ^ K);
      exp_pc += 32'd4;
      pop_cnt++;
    end
    if (rst && mem_req_o && mem_gnt_i) begin
      q.push_back(mem_addr_o);
      gnt_cnt++;
    end
    @(posedge clk);
    #1;
    if (!rst) q.delete();
    if (!hold && q.size() != 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = q.pop_front() ^ K;
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush_i = 1'b0; mem_gnt_i = 1'b0; inst_ready_i = 1'b0;
    mem_rvalid_i = 1'b0; hold = 1'b0; sb_en = 1'b0;
    q.delete();
    #1;
    check("rst_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_vld", {31'd0, inst_valid_o}, 32'd0);
    check("rst_pc", inst_pc_o, 32'd0);
    check("rst_inst", inst_o, NOP);
    cyc(); cyc();
    rst = 1'b1;
    #1;
    check("boot_req", {31'd0, mem_req_o}, 32'd0);
    cyc();
    check("run_req", {31'd0, mem_req_o}, 32'd1);
    check("run_addr", mem_addr_o, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Streaming with a one-cycle memory.
    mem_gnt_i = 1'b1; inst_ready_i = 1'b1; sb_en = 1'b1; exp_pc = '0;
    cyc();
    check("s_lat1", {31'd0, inst_valid_o}, 32'd0);
    cyc();
    check("s_lat2", {31'd0, inst_valid_o}, 32'd1);
    check("s_pc0", inst_pc_o, 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("s_nobubble", {31'd0, inst_valid_o}, 32'd1);
    end

    // Reset mid-stream.
    do_reset();

    // Backpressure: four grants fill the credits.
    mem_gnt_i = 1'b1; inst_ready_i = 1'b0; gnt_cnt = 0;
    repeat (8) cyc();
    check("bp_grants", gnt_cnt, 32'd4);
    check("bp_req", {31'd0, mem_req_o}, 32'd0);
    check("bp_head_pc", inst_pc_o, 32'd0);
    check("bp_head", inst_o, 32'd0 ^ K);

    // Drain with grant stalled: request at 0x10 must stay put.
    inst_ready_i = 1'b1; mem_gnt_i = 1'b0; sb_en = 1'b1; exp_pc = '0; pop_cnt = 0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      check("st_req", {31'd0, mem_req_o}, 32'd1);
      check("st_addr", mem_addr_o, 32'h10);
      cyc();
    end
    check("bp_pops", pop_cnt, 32'd4);
    check("bp_empty", {31'd0, inst_valid_o}, 32'd0);
    mem_gnt_i = 1'b1;
    #1;
    check("st_addr_g", mem_addr_o, 32'h10);
    cyc();
    check("st_next", mem_addr_o, 32'h14);

    // Flush with two responses outstanding.
    do_reset();
    hold = 1'b1; mem_gnt_i = 1'b1; inst_ready_i = 1'b1;
    cyc(); cyc();
    check("f_pre_addr", mem_addr_o, 32'h8);
    flush_i = 1'b1; flush_pc_i = 32'h103; hold = 1'b0;
    sb_en = 1'b1; exp_pc = 32'h100;
    #1;
    check("f_req_low", {31'd0, mem_req_o}, 32'd0);
    cyc();
    flush_i = 1'b0;
    check("f_pc", inst_pc_o, 32'h100);
    check("f_inst_nop", inst_o, NOP);
    for (int i = 0; i < 3; i++) begin
      check("f_drop", {31'd0, inst_valid_o}, 32'd0);
      cyc();
    end
    check("f_vld", {31'd0, inst_valid_o}, 32'd1);
    check("f_first_pc", inst_pc_o, 32'h100);
    check("f_first", inst_o, 32'h100 ^ K);

    // Flush coinciding with a response and a pop.
    flush_i = 1'b1; flush_pc_i = 32'h200;
    #1;
    check("c_req_low", {31'd0, mem_req_o}, 32'd0);
    check("c_rv", {31'd0, mem_rvalid_i & inst_valid_o}, 32'd1);
    cyc();
    flush_i = 1'b0; exp_pc = 32'h200;
    check("c_vld0", {31'd0, inst_valid_o}, 32'd0);
    check("c_pc", inst_pc_o, 32'h200);
    cyc();
    check("c_vld1", {31'd0, inst_valid_o}, 32'd0);
    cyc();
    check("c_vld2", {31'd0, inst_valid_o}, 32'd1);
    check("c_first_pc", inst_pc_o, 32'h200);
    check("c_first", inst_o, 32'h200 ^ K);
    repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
